// File: rtl/i2s_mic_array_if.sv
// i2s_mic_array_if: control, mic lanes, clock outputs and sample handshake of the mic array
interface i2s_mic_array_if #(
  parameter int NUM_MICS = 3,
  parameter int SAMPLE_BITS = 18
);
  logic enable_in;
  logic capture_right_in;
  logic [NUM_MICS-1:0] mic_data_in;
  logic bclk_out;
  logic ws_out;
  logic [NUM_MICS*SAMPLE_BITS-1:0] sample_out;
  logic sample_slot_out;
  logic sample_valid_out;
  logic sample_ready_in;
  logic overrun_out;
  modport master (
    input enable_in, capture_right_in, mic_data_in, sample_ready_in,
    output bclk_out, ws_out, sample_out, sample_slot_out, sample_valid_out, overrun_out
  );
  modport slave (
    output enable_in, capture_right_in, mic_data_in, sample_ready_in,
    input bclk_out, ws_out, sample_out, sample_slot_out, sample_valid_out, overrun_out
  );
endinterface

// File: rtl/i2s_mic_array.sv
// i2s_mic_array: I2S clock master capturing one slot from several mic lanes with a valid/ready output
module i2s_mic_array #(
  parameter int NUM_MICS = 3,
  parameter int BCLK_DIV = 32,
  parameter int SAMPLE_BITS = 18
) (
  input logic clk_in,
  input logic rst_in,
  i2s_mic_array_if.master bus
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int W = NUM_MICS * SAMPLE_BITS;
  localparam logic [DW-1:0] HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(BCLK_DIV - 1);
  localparam logic [4:0] K_LAST = 5'(SAMPLE_BITS - 1);
  localparam logic [5:0] NBITS = 6'(SAMPLE_BITS);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [5:0] bit_cnt, bit_nxt;
  logic run, slot, cap_last, wrap, capture, load;
  logic [W-1:0] shift, shift_nxt;
  assign wrap = div_cnt == LAST;
  assign div_nxt = wrap ? '0 : div_cnt + DW'(1);
  assign bit_nxt = wrap ? bit_cnt + 6'd1 : bit_cnt;
  assign capture = div_cnt == HALF && bit_cnt[5] == slot && {1'b0, bit_cnt[4:0]} < NBITS;
  assign load = cap_last && bus.enable_in;
  for (genvar i = 0; i < NUM_MICS; i++) begin : g_lane
    assign shift_nxt[i*SAMPLE_BITS +: SAMPLE_BITS] = SAMPLE_BITS'({shift[i*SAMPLE_BITS +: SAMPLE_BITS], bus.mic_data_in[i]});
  end
  // bit-clock/word-select generation, lane capture and sample handshake
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      run <= 1'b0;
      slot <= 1'b0;
      cap_last <= 1'b0;
      shift <= '0;
      bus.bclk_out <= 1'b0;
      bus.ws_out <= 1'b0;
      bus.sample_out <= '0;
      bus.sample_slot_out <= 1'b0;
      bus.sample_valid_out <= 1'b0;
      bus.overrun_out <= 1'b0;
    end else begin
      if (bus.enable_in) begin
        div_cnt <= div_nxt;
        bit_cnt <= bit_nxt;
        bus.bclk_out <= div_nxt >= HALF;
        bus.ws_out <= bit_nxt >= 6'd31 && bit_nxt != 6'd63;
        run <= 1'b1;
        if (!run || (wrap && bit_cnt == 6'd63)) slot <= bus.capture_right_in;
        if (capture) shift <= shift_nxt;
        cap_last <= capture && bit_cnt[4:0] == K_LAST;
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bus.bclk_out <= 1'b0;
        bus.ws_out <= 1'b0;
        run <= 1'b0;
        shift <= '0;
        cap_last <= 1'b0;
      end
      if (load) begin
        bus.sample_out <= shift;
        bus.sample_slot_out <= slot;
        bus.sample_valid_out <= 1'b1;
        bus.overrun_out <= bus.sample_valid_out && !bus.sample_ready_in;
      end else begin
        bus.overrun_out <= 1'b0;
        if (bus.sample_valid_out && bus.sample_ready_in) bus.sample_valid_out <= 1'b0;
      end
    end
  end
endmodule
